// File: rtl/sv32_pkg.sv
// Shared Sv32 definitions for the page-table walker: PTE/VPN field positions,
// walker state encoding and PTE classification helpers.
package sv32_pkg;

    localparam int unsigned PAGE_OFFSET_BITS = 12;

    localparam int unsigned PTE_V = 0;
    localparam int unsigned PTE_R = 1;
    localparam int unsigned PTE_W = 2;
    localparam int unsigned PTE_X = 3;
    localparam int unsigned PTE_U = 4;
    localparam int unsigned PTE_G = 5;
    localparam int unsigned PTE_A = 6;
    localparam int unsigned PTE_D = 7;
    localparam int unsigned PTE_PPN_LSB = 10;
    localparam int unsigned PTE_PPN_MSB = 31;

    localparam int unsigned VPN1_MSB = 31;
    localparam int unsigned VPN1_LSB = 22;
    localparam int unsigned VPN0_MSB = 21;
    localparam int unsigned VPN0_LSB = 12;

    localparam int unsigned SATP_MODE_BIT = 31;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_L1_REQ,
        ST_L1_WAIT,
        ST_L0_REQ,
        ST_L0_WAIT,
        ST_FILL,
        ST_FAULT
    } ptw_state_e;

    // Not valid, or writable without being readable (reserved encoding).
    function automatic logic pte_invalid(input logic [31:0] pte);
        return !pte[PTE_V] || (pte[PTE_W] && !pte[PTE_R]);
    endfunction

    function automatic logic pte_is_leaf(input logic [31:0] pte);
        return pte[PTE_R] || pte[PTE_X];
    endfunction

endpackage

// File: rtl/sv32_ptw_victim_sel.sv
// TLB victim selection: lowest-index invalid entry, otherwise a round-robin
// pointer that advances only on fills that actually consume it.
module ptw_victim_sel #(
    parameter int unsigned TLB_ENTRIES = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [TLB_ENTRIES-1:0]         valid_mask,
    input  logic                           fill_en,
    output logic [$clog2(TLB_ENTRIES)-1:0] victim_idx
);

    localparam int unsigned IDX_W = $clog2(TLB_ENTRIES);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             all_valid;

    always_comb begin
        all_valid  = &valid_mask;
        victim_idx = ptr_q;
        // Scan downward so the lowest invalid index is the last one written.
        for (int unsigned i = TLB_ENTRIES; i > 0; i--) begin
            if (!valid_mask[i-1]) begin
                victim_idx = IDX_W'(i - 1);
            end
        end
        ptr_d = ptr_q;
        if (fill_en && all_valid) begin
            ptr_d = (ptr_q == IDX_W'(TLB_ENTRIES - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sv32_ptw.sv
// Sv32 hardware page-table walker: up to two PTE reads over a single-outstanding
// read port, then a one-cycle TLB fill or a page-fault completion.
module sv32_ptw
    import sv32_pkg::*;
#(
    parameter int unsigned TLB_ENTRIES = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [31:0]                    req_vaddr,
    input  logic [31:0]                    req_satp,
    output logic                           mem_req_valid,
    input  logic                           mem_req_ready,
    output logic [31:0]                    mem_req_addr,
    input  logic                           mem_rsp_valid,
    input  logic [31:0]                    mem_rsp_data,
    input  logic [TLB_ENTRIES-1:0]         tlb_valid_mask,
    output logic                           fill_valid,
    output logic [$clog2(TLB_ENTRIES)-1:0] fill_index,
    output logic [19:0]                    fill_vpn,
    output logic [19:0]                    fill_ppn,
    output logic [2:0]                     fill_perms,
    output logic                           done,
    output logic                           fault
);

    ptw_state_e  state_q, state_d;
    logic [19:0] vpn_q, vpn_d;
    logic [19:0] root_q, root_d;
    logic [19:0] base_q, base_d;
    logic [19:0] ppn_q, ppn_d;
    logic [2:0]  perms_q, perms_d;
    logic        bare_q, bare_d;

    logic [$clog2(TLB_ENTRIES)-1:0] victim_idx;
    logic [31:0]                    pte;
    logic                           unused_bits;

    assign pte         = mem_rsp_data;
    assign unused_bits = ^{req_vaddr[PAGE_OFFSET_BITS-1:0], req_satp[30:20],
                           mem_rsp_data[PTE_PPN_MSB:30], mem_rsp_data[PTE_PPN_LSB-1:4]};

    ptw_victim_sel #(
        .TLB_ENTRIES (TLB_ENTRIES)
    ) u_victim_sel (
        .clk        (clk),
        .reset      (reset),
        .valid_mask (tlb_valid_mask),
        .fill_en    (fill_valid),
        .victim_idx (victim_idx)
    );

    always_comb begin
        state_d       = state_q;
        vpn_d         = vpn_q;
        root_d        = root_q;
        base_d        = base_q;
        ppn_d         = ppn_q;
        perms_d       = perms_q;
        bare_d        = bare_q;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        fill_valid    = 1'b0;
        fill_index    = '0;
        fill_vpn      = '0;
        fill_ppn      = '0;
        fill_perms    = '0;
        done          = 1'b0;
        fault         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    vpn_d   = req_vaddr[VPN1_MSB:VPN0_LSB];
                    root_d  = req_satp[19:0];
                    bare_d  = !req_satp[SATP_MODE_BIT];
                    state_d = req_satp[SATP_MODE_BIT] ? ST_L1_REQ : ST_FAULT;
                end
            end
            ST_L1_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {root_q, vpn_q[19:10], 2'b00};
                if (mem_req_ready) begin
                    state_d = ST_L1_WAIT;
                end
            end
            ST_L1_WAIT: begin
                if (mem_rsp_valid) begin
                    if (pte_invalid(pte)) begin
                        state_d = ST_FAULT;
                    end else if (pte_is_leaf(pte)) begin
                        // Superpage leaf must have PPN[0] clear; VPN[0] fills the low PPN.
                        if (pte[19:10] != '0) begin
                            state_d = ST_FAULT;
                        end else begin
                            ppn_d   = {pte[29:20], vpn_q[9:0]};
                            perms_d = pte[PTE_X:PTE_R];
                            state_d = ST_FILL;
                        end
                    end else begin
                        base_d  = pte[29:10];
                        state_d = ST_L0_REQ;
                    end
                end
            end
            ST_L0_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {base_q, vpn_q[9:0], 2'b00};
                if (mem_req_ready) begin
                    state_d = ST_L0_WAIT;
                end
            end
            ST_L0_WAIT: begin
                if (mem_rsp_valid) begin
                    if (pte_invalid(pte) || !pte_is_leaf(pte)) begin
                        state_d = ST_FAULT;
                    end else begin
                        ppn_d   = pte[29:10];
                        perms_d = pte[PTE_X:PTE_R];
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                fill_valid = 1'b1;
                fill_index = victim_idx;
                fill_vpn   = vpn_q;
                fill_ppn   = ppn_q;
                fill_perms = perms_q;
                done       = 1'b1;
                state_d    = ST_IDLE;
            end
            ST_FAULT: begin
                done    = 1'b1;
                fault   = !bare_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            vpn_q   <= '0;
            root_q  <= '0;
            base_q  <= '0;
            ppn_q   <= '0;
            perms_q <= '0;
            bare_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vpn_q   <= vpn_d;
            root_q  <= root_d;
            base_q  <= base_d;
            ppn_q   <= ppn_d;
            perms_q <= perms_d;
            bare_q  <= bare_d;
        end
    end

endmodule
